// File: rtl/demux_driver_if.sv
// rtl/demux_driver_if.sv - word handshake and serial demux drive bundle for demux_driver.
interface demux_driver_if;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       inp;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] word_cnt;

  modport master (
    output data_in, data_valid,
    input  data_ready, inp, sel, busy, done, word_cnt
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, inp, sel, busy, done, word_cnt
  );
endinterface

// File: rtl/demux_driver.sv
// rtl/demux_driver.sv - serialises a 4-bit word onto a 1:4 demux, HOLD cycles per channel.
module demux_driver #(
  parameter int HOLD = 1
) (
  input  logic           clk,
  input  logic           rst,
  demux_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       inp_q, inp_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [7:0] word_cnt_q, word_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= 4'd0;
      cnt_q      <= 4'd0;
      sel_q      <= 2'd0;
      inp_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      word_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      inp_q      <= inp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.data_valid && ready_q) begin
          data_d  = bus.data_in;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 4'd0;
          if (sel_q == 2'd3) begin
            sel_d   = 2'd0;
            state_d = DONE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight from a flop.
  always_comb begin
    inp_d      = (state_d == DRIVE) ? data_d[sel_d] : 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    ready_d    = (state_d == IDLE);
    word_cnt_d = word_cnt_q + {7'd0, (state_q == DRIVE) && (state_d == DONE)};
  end

  assign bus.data_ready = ready_q;
  assign bus.inp        = inp_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_demux_driver.sv
// tb/tb_demux_driver.sv - scoreboard bench for demux_driver with HOLD=1 and HOLD=3 instances.
module tb_demux_driver;

  typedef struct packed {
    logic       busy;
    logic [1:0] sel;
    logic       inp;
    logic       done;
    logic       ready;
  } obs_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  demux_driver_if if0 ();
  demux_driver_if if1 ();

  demux_driver #(.HOLD(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  demux_driver #(.HOLD(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic valid, input logic [3:0] data);
    if (idx == 0) begin
      if0.data_valid = valid;
      if0.data_in    = data;
    end else begin
      if1.data_valid = valid;
      if1.data_in    = data;
    end
  endtask

  function automatic obs_t get_obs(input int idx);
    obs_t o;
    if (idx == 0) o = '{busy: if0.busy, sel: if0.sel, inp: if0.inp, done: if0.done, ready: if0.data_ready};
    else          o = '{busy: if1.busy, sel: if1.sel, inp: if1.inp, done: if1.done, ready: if1.data_ready};
    return o;
  endfunction

  function automatic logic [7:0] get_wc(input int idx);
    return (idx == 0) ? if0.word_cnt : if1.word_cnt;
  endfunction

  // Called at a falling edge with the DUT idle; expectations cover every cycle to the next IDLE.
  task automatic send(input int idx, input int h, input logic [3:0] d, input bit toggle);
    obs_t e;
    check("ready_before_word", 32'(get_obs(idx).ready), 32'd1);
    drive(idx, 1'b1, d);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < h; j++)
        exp_q.push_back('{busy: 1'b1, sel: 2'(k), inp: d[k], done: 1'b0, ready: 1'b0});
    exp_q.push_back('{busy: 1'b1, sel: 2'd0, inp: 1'b0, done: 1'b1, ready: 1'b0});
    exp_q.push_back('{busy: 1'b0, sel: 2'd0, inp: 1'b0, done: 1'b0, ready: 1'b1});
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("word_cycle", 32'(get_obs(idx)), 32'(e));
      if (toggle && exp_q.size() > 0) drive(idx, 1'($urandom_range(0, 1)), 4'($urandom));
      else                            drive(idx, 1'b0, 4'd0);
    end
  endtask

  initial begin
    obs_t o;
    int   pulses;
    int   last_i;
    logic prev_done;
    logic [7:0] exp_cnt;

    rst = 1'b1;
    drive(0, 1'b0, 4'd0);
    drive(1, 1'b0, 4'd0);
    #3;
    check("reset_obs0", 32'(get_obs(0)), 32'(obs_t'(6'b0_00_0_0_1)));
    check("reset_obs1", 32'(get_obs(1)), 32'(obs_t'(6'b0_00_0_0_1)));
    check("reset_wc0", 32'(get_wc(0)), 32'd0);

    // First edge after reset release must already accept a word.
    @(negedge clk);
    rst = 1'b0;
    send(0, 1, 4'b1010, 1'b0);
    check("wc0_after_1010", 32'(get_wc(0)), 32'd1);

    send(1, 3, 4'b0110, 1'b0);
    check("wc1_after_0110", 32'(get_wc(1)), 32'd1);

    send(0, 1, 4'b1101, 1'b1);
    check("wc0_after_toggle", 32'(get_wc(0)), 32'd2);
    send(1, 3, 4'b1001, 1'b1);
    check("wc1_after_toggle", 32'(get_wc(1)), 32'd2);

    // Asynchronous reset while sel=2.
    drive(0, 1'b1, 4'b0101);
    @(negedge clk);
    drive(0, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_drive_sel", 32'(get_obs(0).sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_obs", 32'(get_obs(0)), 32'(obs_t'(6'b0_00_0_0_1)));
    check("async_reset_wc", 32'(get_wc(0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_done", 32'(get_obs(0).done), 32'd0);
    end
    check("post_reset_wc", 32'(get_wc(0)), 32'd0);
    send(0, 1, 4'b1010, 1'b0);
    check("wc_after_recovery", 32'(get_wc(0)), 32'd1);

    // 256 back-to-back words with data_valid held high.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses    = 0;
    last_i    = 0;
    prev_done = 1'b0;
    exp_cnt   = 8'd0;
    drive(0, 1'b1, 4'($urandom));
    for (int i = 0; i < 256 * 6; i++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.done) begin
        pulses++;
        exp_cnt = exp_cnt + 8'd1;
        check("b2b_done_width", 32'(prev_done), 32'd0);
        check("b2b_word_cnt", 32'(get_wc(0)), 32'(exp_cnt));
        if (pulses > 1) check("b2b_spacing", 32'(i - last_i), 32'd6);
        last_i = i;
      end
      prev_done = o.done;
      if (o.ready) drive(0, 1'b1, 4'($urandom));
    end
    drive(0, 1'b0, 4'd0);
    check("b2b_pulses", 32'(pulses), 32'd256);
    check("b2b_wrap", 32'(get_wc(0)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle_after", 32'(get_obs(0)), 32'(obs_t'(6'b0_00_0_0_1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_driver.md
DEMUX_DRIVER -- requirements
Module: demux_driver

Interface
REQ-001 The block SHALL have parameter HOLD, default 1, giving the cycles each channel is driven; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port data_in, input, 4 bits: parallel word; bit k is destined for demux channel k.
REQ-005 The block SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-006 The block SHALL have port data_ready, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port inp, output, 1 bit: serial data bit to the 1:4 demux data input.
REQ-008 The block SHALL have port sel, output, 2 bits: channel select to the 1:4 demux.
REQ-009 The block SHALL have port busy, output, 1 bit: a word is being driven.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last channel of a word.
REQ-011 The block SHALL have port word_cnt, output, 8 bits: count of completed words.

Function
REQ-012 All outputs SHALL be registered; there are no combinational input-to-output paths.
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-014 data_ready SHALL be 1 only in IDLE; busy SHALL be 1 in DRIVE and DONE.
REQ-015 A handshake SHALL occur on a rising edge where data_valid=1 and data_ready=1.
REQ-016 On handshake the block SHALL capture data_in into an internal 4-bit register, set sel=0 and inp=data_in[0], clear the hold counter, and enter DRIVE.
REQ-017 In DRIVE each sel value SHALL be held exactly HOLD cycles, with inp=captured[sel] throughout.
REQ-018 After HOLD cycles the block SHALL advance sel in the order 0,1,2,3 and update inp on the same edge.
REQ-019 After sel=3 has been held HOLD cycles, the block SHALL enter DONE, set inp=0 and sel=0, and pulse done=1 for exactly one cycle.
REQ-020 On entry to DONE, word_cnt SHALL increment by 1 modulo 256, wrapping 255 to 0.
REQ-021 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 For a handshake at edge T, sel=k SHALL be valid for cycles T+1+k*HOLD .. T+(k+1)*HOLD; done SHALL be high in cycle T+4*HOLD+1; data_ready SHALL be high again from T+4*HOLD+2.
REQ-023 Changes on data_in or data_valid during DRIVE or DONE SHALL be ignored and SHALL NOT corrupt the captured word.
REQ-024 data_valid held continuously high SHALL produce back-to-back words separated only by the DONE cycle and one IDLE cycle.
REQ-025 In IDLE, inp and sel SHALL be 0, done SHALL be 0, and word_cnt SHALL hold its value.

Reset
REQ-026 On rst=1 the block SHALL, immediately and independent of clk, enter IDLE with inp=0, sel=0, busy=0, done=0, word_cnt=0, data_ready=1, and the captured word and hold counter cleared.
REQ-027 Reset asserted mid-DRIVE SHALL discard the word with no done pulse and no word_cnt increment.
REQ-028 After rst deasserts, the first rising edge SHALL be able to accept a handshake.

Verification
REQ-029 Reset: assert rst asynchronously between edges -> all outputs take their reset values before the next edge; data_ready=1.
REQ-030 HOLD=1, data_in=4'b1010, one handshake -> (sel,inp) = (0,0),(1,1),(2,0),(3,1) on consecutive cycles, then done=1 for one cycle, word_cnt=1.
REQ-031 HOLD=3, data_in=4'b0110 -> each sel held 3 cycles with inp=0,1,1,0; done in cycle T+13; data_ready=1 again at T+14.
REQ-032 Toggle data_in every cycle during DRIVE -> serial output still matches the word captured at handshake.
REQ-033 rst pulsed while sel=2 -> no done pulse; word_cnt unchanged at 0; next handshake drives a full word normally.
REQ-034 256 back-to-back words with data_valid held high -> word_cnt wraps to 0; exactly 256 done pulses observed, each one cycle wide.
